// File: rtl/modport_core.sv
// modport_core: complex multiply by a 4-bit weight, 4-tap sliding window sum, round/saturate to 9 bits
module modport_core (
  input  logic               clk,
  input  logic               rstb,
  input  logic signed [11:0] in_data_i,
  input  logic signed [11:0] in_data_q,
  input  logic signed [3:0]  in_w_i,
  input  logic signed [3:0]  in_w_q,
  input  logic               in_en,
  input  logic               done,
  output logic signed [8:0]  out_data_i,
  output logic signed [8:0]  out_data_q,
  output logic               out_en,
  output logic               out_done
);
  logic signed [11:0] xi, xq;
  logic signed [3:0]  wi, wq;
  logic               v1, d1, v2, d2, v3, d3;
  logic signed [16:0] pr, pq, pr_n, pq_n;
  logic signed [16:0] ti [3];
  logic signed [16:0] tq [3];
  logic signed [19:0] si, sq, si_n, sq_n;

  function automatic logic signed [8:0] rnd_sat(input logic signed [19:0] s);
    logic signed [19:0] r;
    r = (s + 20'sd128) >>> 8;
    return r > 20'sd255 ? 9'h0ff : r < -20'sd256 ? 9'h100 : r[8:0];
  endfunction

  assign pr_n = 17'(xi) * 17'(wi) - 17'(xq) * 17'(wq);
  assign pq_n = 17'(xi) * 17'(wq) + 17'(xq) * 17'(wi);
  // the window sum always includes the product entering this cycle
  assign si_n = 20'(pr) + 20'(ti[0]) + 20'(ti[1]) + 20'(ti[2]);
  assign sq_n = 20'(pq) + 20'(tq[0]) + 20'(tq[1]) + 20'(tq[2]);

  always_ff @(posedge clk) begin
    if (rstb) begin
      {xi, xq, wi, wq, pr, pq, si, sq} <= '0;
      {v1, d1, v2, d2, v3, d3} <= '0;
      ti <= '{default: '0};
      tq <= '{default: '0};
      {out_data_i, out_data_q, out_en, out_done} <= '0;
    end else begin
      v1 <= in_en;
      d1 <= in_en & done;
      if (in_en) {xi, xq, wi, wq} <= {in_data_i, in_data_q, in_w_i, in_w_q};
      v2 <= v1;
      d2 <= d1;
      pr <= pr_n;
      pq <= pq_n;
      v3 <= v2;
      d3 <= d2;
      si <= si_n;
      sq <= sq_n;
      // a frame's last sample leaves the history empty for the next frame
      if (v2 && d2) begin
        ti <= '{default: '0};
        tq <= '{default: '0};
      end else if (v2) begin
        ti <= '{pr, ti[0], ti[1]};
        tq <= '{pq, tq[0], tq[1]};
      end
      out_en <= v3;
      out_done <= d3;
      out_data_i <= rnd_sat(si);
      out_data_q <= rnd_sat(sq);
    end
  end
endmodule

// File: tb/tb_modport_core.sv
// tb_modport_core: directed stimulus, per-cycle check against a frame/queue model, plus literal pins
module tb_modport_core;
  logic clk = 0;
  logic rstb;
  logic signed [11:0] in_data_i, in_data_q;
  logic signed [3:0] in_w_i, in_w_q;
  logic in_en, done;
  logic signed [8:0] out_data_i, out_data_q;
  logic out_en, out_done;

  modport_core dut (
    .clk(clk), .rstb(rstb), .in_data_i(in_data_i), .in_data_q(in_data_q),
    .in_w_i(in_w_i), .in_w_q(in_w_q), .in_en(in_en), .done(done),
    .out_data_i(out_data_i), .out_data_q(out_data_q), .out_en(out_en), .out_done(out_done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int i; int q; int d; } exp_t;
  typedef struct { int i; int q; int d; } out_t;
  exp_t mq[$];
  out_t log_q[$];
  int hist_i[$], hist_q[$];
  int cyc = 0;
  int checks = 0, failures = 0;
  bit rst_seen = 0;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc, got, exp);
    end
  endtask

  function automatic int sat9(input int s);
    int y;
    y = (s + 128) >>> 8;
    return y > 255 ? 255 : y < -256 ? -256 : y;
  endfunction

  // model: each accepted sample emerges three edges later with the sum of its frame's last four products
  always @(posedge clk) begin
    cyc++;
    rst_seen = rstb;
    if (rstb) begin
      mq.delete();
      hist_i.delete();
      hist_q.delete();
    end else if (in_en) begin
      int si, sq;
      exp_t e;
      hist_i.push_back(int'(in_data_i) * int'(in_w_i) - int'(in_data_q) * int'(in_w_q));
      hist_q.push_back(int'(in_data_i) * int'(in_w_q) + int'(in_data_q) * int'(in_w_i));
      if (hist_i.size() > 4) begin
        void'(hist_i.pop_front());
        void'(hist_q.pop_front());
      end
      si = 0;
      sq = 0;
      foreach (hist_i[k]) begin
        si += hist_i[k];
        sq += hist_q[k];
      end
      e.due = cyc + 3;
      e.i = sat9(si);
      e.q = sat9(sq);
      e.d = int'(done);
      mq.push_back(e);
      if (done) begin
        hist_i.delete();
        hist_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    bit e_en;
    e_en = mq.size() > 0 && mq[0].due == cyc;
    chk("out_en", int'(out_en), int'(e_en));
    if (rst_seen) begin
      chk("rst_data_i", int'(out_data_i), 0);
      chk("rst_data_q", int'(out_data_q), 0);
      chk("rst_done", int'(out_done), 0);
    end else if (e_en) begin
      chk("out_data_i", int'(out_data_i), mq[0].i);
      chk("out_data_q", int'(out_data_q), mq[0].q);
      chk("out_done", int'(out_done), mq[0].d);
      void'(mq.pop_front());
    end else begin
      chk("out_done_idle", int'(out_done), 0);
    end
    if (out_en) log_q.push_back('{int'(out_data_i), int'(out_data_q), int'(out_done)});
  end

  task automatic send(input int xi, input int xq, input int wi, input int wq, input bit d);
    in_data_i = 12'(xi);
    in_data_q = 12'(xq);
    in_w_i = 4'(wi);
    in_w_q = 4'(wq);
    done = d;
    in_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_en = 0;
    done = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string n, input int idx, input int ei, input int eq, input int ed);
    if (idx >= log_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing output %0d (got %0d outputs)", n, idx, log_q.size());
    end else begin
      chk({n, "_i"}, log_q[idx].i, ei);
      chk({n, "_q"}, log_q[idx].q, eq);
      chk({n, "_done"}, log_q[idx].d, ed);
    end
  endtask

  initial begin
    rstb = 1;
    in_en = 1;
    done = 1;
    in_data_i = 12'sd1000;
    in_data_q = 0;
    in_w_i = 4'sd2;
    in_w_q = 0;
    repeat (2) @(negedge clk);
    chk("reset_log_empty", log_q.size(), 0);
    rstb = 0;
    idle(2);
    log_q.delete();
    send(1000, 0, 2, 0, 1);
    idle(6);
    lit("scalar", 0, 8, 0, 1);
    chk("scalar_count", log_q.size(), 1);
    log_q.delete();
    send(100, 200, 3, -1, 1);
    idle(6);
    lit("cmul", 0, 2, 2, 1);
    log_q.delete();
    for (int k = 0; k < 5; k++) send(2047, 0, 7, 0, k == 4);
    idle(6);
    lit("win0", 0, 56, 0, 0);
    lit("win1", 1, 112, 0, 0);
    lit("win2", 2, 168, 0, 0);
    lit("win3", 3, 224, 0, 0);
    lit("win4", 4, 224, 0, 1);
    log_q.delete();
    for (int k = 0; k < 4; k++) send(-2048, -2048, -8, -8, k == 3);
    idle(6);
    lit("satp3", 3, 0, 255, 1);
    log_q.delete();
    for (int k = 0; k < 4; k++) send(-2048, -2048, 7, 7, k == 3);
    idle(6);
    lit("satn0", 0, 0, -112, 0);
    lit("satn1", 1, 0, -224, 0);
    lit("satn2", 2, 0, -256, 0);
    log_q.delete();
    send(500, 0, 1, 0, 0);
    send(500, 0, 1, 0, 1);
    send(1000, 0, 2, 0, 0);
    idle(1);
    done = 1;
    idle(1);
    send(1000, 0, 2, 0, 1);
    idle(6);
    lit("clr0", 0, 2, 0, 0);
    lit("clr1", 1, 4, 0, 1);
    lit("clr2", 2, 8, 0, 0);
    lit("clr3", 3, 16, 0, 1);
    log_q.delete();
    send(2047, 0, 7, 0, 0);
    idle(2);
    send(2047, 0, 7, 0, 0);
    idle(1);
    send(2047, 0, 7, 0, 1);
    idle(6);
    lit("gap2", 2, 168, 0, 1);
    log_q.delete();
    send(2047, 0, 7, 0, 0);
    send(2047, 0, 7, 0, 0);
    rstb = 1;
    send(2047, 0, 7, 0, 1);
    rstb = 0;
    idle(6);
    chk("midrst_count", log_q.size(), 0);
    send(1000, 0, 2, 0, 1);
    idle(6);
    lit("post_rst", 0, 8, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modport_core.md
# modport_core

Streaming complex multiply-and-window-sum datapath. It multiplies each 12-bit complex input sample by a 4-bit complex weight and sums the last four products in a sliding window. The sum is rounded and saturated to a 9-bit complex output. The block sits behind the team's `dut_io` bench interface and is driven as a frame-oriented valid-only stream (no backpressure).

## Interface
- No parameters. Tap count is 4, shift is 8, widths are fixed.
- `clk` in 1: single clock; all logic on rising edge.
- `rstb` in 1: reset. Synchronous and active-high (1 = reset), despite the name.
- `in_data_i` in 12: input sample, real part, signed two's complement.
- `in_data_q` in 12: input sample, imaginary part, signed.
- `in_w_i` in 4: weight, real part, signed (-8..7).
- `in_w_q` in 4: weight, imaginary part, signed.
- `in_en` in 1: input valid; data, weight and `done` are sampled only when high.
- `done` in 1: the sample accepted this cycle is the last of its frame.
- `out_data_i` out 9: output real part, signed.
- `out_data_q` out 9: output imaginary part, signed.
- `out_en` out 1: output valid, one cycle per accepted sample.
- `out_done` out 1: high together with `out_en` for the frame's last sample.

## Operation
- Per accepted sample:
  - `pr = xi*wi - xq*wq`
  - `pq = xi*wq + xq*wi`
  - Each partial product is 16-bit signed; `pr`/`pq` are 17-bit signed, full precision with no truncation.
- Window:
  - Hold the 4 most recent products (complex) in a shift register.
  - It shifts only on `in_en=1`; `in_en=0` cycles leave it untouched.
  - Empty taps read as 0.
  - `S = sum` of the 4 taps, including the new one, computed in 20-bit signed per component.
- Output scaling, per component:
  - `y = (S + 128) >>> 8` (arithmetic shift, round half up).
  - Saturate to [-256, 255].
- Frame end: when a sample is accepted with `done=1`, its output is produced normally with the window including it. Then all window taps clear to 0, so the next frame starts with empty history.
- `done` with `in_en=0` is ignored.
- No backpressure: the block accepts a sample on every `in_en=1` cycle, back-to-back.

## Timing
- Latency is exactly 3 cycles.
  - Sample accepted at rising edge t (`in_en=1`).
  - `out_en`/`out_data`/`out_done` are valid from edge t+3 until edge t+4.
- Pipeline stages:
  - Input register.
  - Product register.
  - Window sum, round/saturate, output register.
- Window clear takes effect for a sample accepted at t+1 following a `done` at t, even back-to-back.
- `out_en` is high for exactly one cycle per accepted sample. Gaps in `in_en` reproduce as gaps in `out_en`, at the same 3-cycle offset.
- Reset (`rstb=1` at an edge):
  - Next cycle: `out_data_i=out_data_q=0`, `out_en=0`, `out_done=0`.
  - Window and all pipeline valid bits clear.
  - Samples in flight are discarded and produce no output.
  - Inputs are ignored while `rstb=1`.
- Reset mid-frame: the frame is aborted and no `out_done` is generated for it.

## Test plan
- **Reset:** hold `rstb=1` for 2 cycles with `in_en=1` → all outputs 0. After release, first output appears only 3 cycles after the first post-reset sample.
- **Scalar path:** x=(1000,0), w=(2,0), `in_en=1`, `done=1` → 3 cycles later `out_en=1`, out=(8,0), `out_done=1`.
- **Complex multiply:** x=(100,200), w=(3,-1), `done=1` → out=(2,2), since pr=pq=500.
- **Window:** 5 back-to-back samples x=(2047,0), w=(7,0), `done` on the 5th → outputs 56, 112, 168, 224, 224 (imag 0). `out_done` only with the 5th.
- **Saturation:**
  - 4 samples x=(-2048,-2048), w=(-8,-8) → out_q reaches +255.
  - 4 samples x=(-2048,-2048), w=(7,7) → out_q reaches -256.
- **Frame clear, gaps, mid-frame reset:**
  - `done` on sample 2, then sample 3 x=(1000,0), w=(2,0) → sample 3 out=(8,0), with no history.
  - Insert `in_en=0` gaps → `out_en` gaps match.
  - Assert `rstb` mid-frame → no pending outputs emerge.
